// File: rtl/db_ptr_ctrl.sv
// Pointer/handshake controller for the 64-byte non-circular data buffer FIFO.
// Stores write combinationally; gets read one cycle later, data valid the cycle after.
module db_ptr_ctrl #(
    parameter int DEPTH = 64,
    parameter int PTR_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             store_tx_data,
    input  logic             store_rx_data,
    input  logic             get_tx_data,
    input  logic             get_rx_data,
    input  logic             clear,
    input  logic             flush,
    output logic             write_en,
    output logic [PTR_W-1:0] write_ptr,
    output logic             read_en,
    output logic [PTR_W-1:0] read_ptr,
    output logic [PTR_W-1:0] buff_occ,
    output logic             full,
    output logic             empty,
    output logic             tx_data_valid,
    output logic             rx_data_valid,
    output logic             overflow,
    output logic             underflow,
    output logic             store_collision
);

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

    logic [PTR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [PTR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             pend_q, pend_d;
    logic             pend_tx_q, pend_tx_d;
    logic             vld_q, vld_d;
    logic             vld_tx_q, vld_tx_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             col_q, col_d;

    logic kill;
    logic store_req;
    logic store_acc;
    logic get_req;
    logic get_acc;
    logic rd_go;

    always_comb begin
        kill      = clear | flush;
        buff_occ  = wr_cnt_q - rd_cnt_q - PTR_W'(pend_q);
        full      = (buff_occ == DEPTH_P);
        empty     = (buff_occ == '0);
        store_req = store_tx_data | store_rx_data;
        // Non-circular: the write pointer can never run past the last byte
        store_acc = store_req & ~full & (wr_cnt_q != DEPTH_P) & ~kill;
        get_req   = get_tx_data | get_rx_data;
        get_acc   = get_req & ~empty & ~kill;
        rd_go     = pend_q & ~kill;

        write_en      = store_acc;
        write_ptr     = store_acc ? wr_cnt_q + ONE : wr_cnt_q;
        read_en       = rd_go;
        read_ptr      = rd_go ? rd_cnt_q + ONE : rd_cnt_q;
        tx_data_valid = vld_q & vld_tx_q;
        rx_data_valid = vld_q & ~vld_tx_q;
        overflow        = ovf_q;
        underflow       = unf_q;
        store_collision = col_q;

        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        pend_d    = 1'b0;
        pend_tx_d = pend_tx_q;
        vld_d     = 1'b0;
        vld_tx_d  = vld_tx_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        col_d     = col_q;

        if (kill) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            col_d    = 1'b0;
        end else begin
            wr_cnt_d  = wr_cnt_q + PTR_W'(store_acc);
            rd_cnt_d  = rd_cnt_q + PTR_W'(rd_go);
            // Last byte drained with no new write: rewind for the next packet
            if (rd_go && (rd_cnt_q + ONE == wr_cnt_q) && !store_acc) begin
                wr_cnt_d = '0;
                rd_cnt_d = '0;
            end
            pend_d    = get_acc;
            pend_tx_d = get_acc ? get_tx_data : pend_tx_q;
            vld_d     = rd_go;
            vld_tx_d  = rd_go ? pend_tx_q : vld_tx_q;
            ovf_d     = ovf_q | (store_req & ~store_acc);
            unf_d     = unf_q | (get_req & ~get_acc);
            col_d     = col_q | (store_tx_data & store_rx_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            pend_q    <= 1'b0;
            pend_tx_q <= 1'b0;
            vld_q     <= 1'b0;
            vld_tx_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            col_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            pend_q    <= pend_d;
            pend_tx_q <= pend_tx_d;
            vld_q     <= vld_d;
            vld_tx_q  <= vld_tx_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            col_q     <= col_d;
        end
    end

endmodule

// File: tb/tb_db_ptr_ctrl.sv
// Scoreboard bench for db_ptr_ctrl: a byte-count reference model queues expected
// write/read/valid events and per-cycle status; a negedge monitor consumes them.
module tb_db_ptr_ctrl;

    localparam int DEPTH = 64;
    localparam int PTR_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic store_tx_data = 1'b0, store_rx_data = 1'b0;
    logic get_tx_data = 1'b0, get_rx_data = 1'b0;
    logic clear = 1'b0, flush = 1'b0;
    logic             write_en, read_en;
    logic [PTR_W-1:0] write_ptr, read_ptr, buff_occ;
    logic full, empty, tx_data_valid, rx_data_valid;
    logic overflow, underflow, store_collision;

    db_ptr_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .store_tx_data(store_tx_data), .store_rx_data(store_rx_data),
        .get_tx_data(get_tx_data), .get_rx_data(get_rx_data),
        .clear(clear), .flush(flush),
        .write_en(write_en), .write_ptr(write_ptr),
        .read_en(read_en), .read_ptr(read_ptr),
        .buff_occ(buff_occ), .full(full), .empty(empty),
        .tx_data_valid(tx_data_valid), .rx_data_valid(rx_data_valid),
        .overflow(overflow), .underflow(underflow),
        .store_collision(store_collision)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int val; } ev_t;
    typedef struct {
        int cyc; int occ; int wp; int rp;
        bit ovf; bit unf; bit col;
    } st_t;

    ev_t qw[$], qr[$], qv[$];
    st_t qs[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: byte counts written/read plus reads in flight
    int m_wr, m_rd;
    int m_pend[$];
    bit m_ovf, m_unf, m_col;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void fail_ev(string name, int c);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d (event at cycle %0d)", name, cyc, c);
    endfunction

    function automatic void model_reset();
        m_wr = 0;
        m_rd = 0;
        m_pend.delete();
        m_ovf = 0;
        m_unf = 0;
        m_col = 0;
        qw.delete();
        qr.delete();
        qv.delete();
        qs.delete();
    endfunction

    task automatic step(input bit stx, input bit srx, input bit gtx,
                        input bit grx, input bit clr, input bit fl);
        int  occ;
        bit  kill, sreq, sacc, greq, gacc, rgo;
        int  src;
        @(posedge clk);
        #1;
        store_tx_data = stx;
        store_rx_data = srx;
        get_tx_data   = gtx;
        get_rx_data   = grx;
        clear         = clr;
        flush         = fl;
        occ  = m_wr - m_rd - m_pend.size();
        kill = clr | fl;
        sreq = stx | srx;
        greq = gtx | grx;
        sacc = sreq && occ != DEPTH && m_wr < DEPTH && !kill;
        gacc = greq && occ != 0 && !kill;
        rgo  = (m_pend.size() != 0) && !kill;
        src  = rgo ? m_pend[0] : 0;
        if (sacc) qw.push_back('{cyc, m_wr + 1});
        if (rgo) begin
            qr.push_back('{cyc, m_rd + 1});
            qv.push_back('{cyc + 1, src});
        end
        qs.push_back('{cyc, occ, sacc ? m_wr + 1 : m_wr,
                       rgo ? m_rd + 1 : m_rd, m_ovf, m_unf, m_col});
        if (kill) begin
            m_wr = 0;
            m_rd = 0;
            m_pend.delete();
            m_ovf = 0;
            m_unf = 0;
            m_col = 0;
        end else begin
            if (sreq && !sacc) m_ovf = 1;
            if (greq && !gacc) m_unf = 1;
            if (stx && srx) m_col = 1;
            if (rgo) begin
                void'(m_pend.pop_front());
                m_rd++;
            end
            if (sacc) m_wr++;
            if (rgo && !sacc && m_rd == m_wr) begin
                m_wr = 0;
                m_rd = 0;
            end
            if (gacc) m_pend.push_back(gtx ? 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (qw.size() != 0 && qw[0].cyc < cyc) begin
                fail_ev("missing_write", qw[0].cyc);
                void'(qw.pop_front());
            end
            while (qr.size() != 0 && qr[0].cyc < cyc) begin
                fail_ev("missing_read", qr[0].cyc);
                void'(qr.pop_front());
            end
            while (qv.size() != 0 && qv[0].cyc < cyc) begin
                fail_ev("missing_valid", qv[0].cyc);
                void'(qv.pop_front());
            end
            if (write_en) begin
                if (qw.size() != 0 && qw[0].cyc == cyc) begin
                    chk("write_ptr", int'(write_ptr), qw[0].val);
                    void'(qw.pop_front());
                end else fail_ev("unexpected_write_en", cyc);
            end
            if (read_en) begin
                if (qr.size() != 0 && qr[0].cyc == cyc) begin
                    chk("read_ptr", int'(read_ptr), qr[0].val);
                    void'(qr.pop_front());
                end else fail_ev("unexpected_read_en", cyc);
            end
            if (tx_data_valid && rx_data_valid) fail_ev("both_valid", cyc);
            else if (tx_data_valid || rx_data_valid) begin
                if (qv.size() != 0 && qv[0].cyc == cyc) begin
                    chk("valid_src_tx", int'(tx_data_valid), qv[0].val);
                    void'(qv.pop_front());
                end else fail_ev("unexpected_valid", cyc);
            end
            while (qs.size() != 0 && qs[0].cyc < cyc) void'(qs.pop_front());
            if (qs.size() != 0 && qs[0].cyc == cyc) begin
                chk("buff_occ", int'(buff_occ), qs[0].occ);
                chk("full", int'(full), int'(qs[0].occ == DEPTH));
                chk("empty", int'(empty), int'(qs[0].occ == 0));
                chk("write_ptr_now", int'(write_ptr), qs[0].wp);
                chk("read_ptr_now", int'(read_ptr), qs[0].rp);
                chk("overflow", int'(overflow), int'(qs[0].ovf));
                chk("underflow", int'(underflow), int'(qs[0].unf));
                chk("store_collision", int'(store_collision), int'(qs[0].col));
                void'(qs.pop_front());
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_write_en"}, int'(write_en), 0);
        chk({tag, "_read_en"}, int'(read_en), 0);
        chk({tag, "_write_ptr"}, int'(write_ptr), 0);
        chk({tag, "_read_ptr"}, int'(read_ptr), 0);
        chk({tag, "_buff_occ"}, int'(buff_occ), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_tx_valid"}, int'(tx_data_valid), 0);
        chk({tag, "_rx_valid"}, int'(rx_data_valid), 0);
        chk({tag, "_flags"},
            int'({overflow, underflow, store_collision}), 0);
    endtask

    initial begin
        model_reset();
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        repeat (3) step(1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);
        idle(3);
        chk("drain_empty", int'(empty), 1);
        chk("drain_wptr", int'(write_ptr), 0);

        for (int i = 0; i < DEPTH; i++) step(i[0], ~i[0], 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        chk("fill_full", int'(full), 1);
        chk("fill_occ", int'(buff_occ), DEPTH);
        chk("fill_overflow", int'(overflow), 1);

        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(3);
        chk("empty_get_underflow", int'(underflow), 1);

        step(0, 0, 0, 0, 0, 1);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        idle(3);
        chk("dual_get_occ", int'(buff_occ), 1);

        step(0, 0, 0, 0, 1, 0);
        repeat (5) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(3);
        chk("flush_occ", int'(buff_occ), 0);

        repeat (10) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("collision_occ", int'(buff_occ), 11);
        chk("collision_flag", int'(store_collision), 1);
        @(posedge clk);
        #1;
        get_tx_data = 1'b0;
        #1;
        chk("pre_reset_read_en", int'(read_en), 1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        chk("midreset_no_valid", int'(tx_data_valid | rx_data_valid), 0);
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 199) < 2, $urandom_range(0, 199) < 2);
        end
        idle(4);
        @(posedge clk);
        #2;
        if (qw.size() != 0) fail_ev("leftover_write", qw[0].cyc);
        if (qr.size() != 0) fail_ev("leftover_read", qr[0].cyc);
        if (qv.size() != 0) fail_ev("leftover_valid", qv[0].cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/db_ptr_ctrl.md
Name: db_ptr_ctrl

Overview:
- Pointer and handshake controller that drives the data-buffer FIFO.
- Converts store and get requests from the AHB side and the USB side into the FIFO's write_en/write_ptr and read_en/read_ptr controls.
- Aligns reads with the FIFO's one-cycle get delay and its registered data output.
- Tracks occupancy, full/empty and error conditions for the 64-byte, non-circular packet buffer.

Parameters:
- DEPTH, 64, buffer capacity in bytes; pointers range 0..DEPTH.
- PTR_W, 7, pointer and occupancy width; must hold DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- store_tx_data  input  1  AHB side writes one byte into the buffer.
- store_rx_data  input  1  USB RX side writes one byte into the buffer.
- get_tx_data  input  1  USB TX side requests one byte; also routed to the FIFO.
- get_rx_data  input  1  AHB side requests one byte; also routed to the FIFO.
- clear  input  1  AHB buffer clear.
- flush  input  1  protocol flush.
- write_en  output  1  FIFO write strobe.
- write_ptr  output  PTR_W  FIFO write pointer (1-based during a write).
- read_en  output  1  FIFO read strobe.
- read_ptr  output  PTR_W  FIFO read pointer (1-based during a read).
- buff_occ  output  PTR_W  true occupancy, including pending reads.
- full  output  1  buff_occ == DEPTH.
- empty  output  1  buff_occ == 0.
- tx_data_valid  output  1  tx_packet_data is valid this cycle.
- rx_data_valid  output  1  rx_data is valid this cycle.
- overflow  output  1  sticky: a store was dropped.
- underflow  output  1  sticky: a get was dropped.
- store_collision  output  1  sticky: both store requests in the same cycle.

Behaviour:
- Reset (async, rst=1): wr_cnt=0, rd_cnt=0, no read pending, all flags 0.
  - All outputs are 0, except empty=1.
- Store acceptance:
  - A store is accepted when (store_tx_data|store_rx_data) & ~full & ~clear & ~flush.
  - Acceptance is combinational: write_en=1 and write_ptr=wr_cnt+1 in the same cycle. wr_cnt increments at the clock edge.
  - When no write is occurring, write_ptr=wr_cnt.
- Both stores in the same cycle: exactly one byte is written, and store_collision is set.
- Store while full: write_en stays 0 and overflow is set.
- Get acceptance (cycle N):
  - A get is accepted when (get_tx_data|get_rx_data) & (buff_occ != 0) & ~clear & ~flush.
  - get_tx_data has priority. The accepted source is latched into the 1-bit pending register.
- Read pipeline:
  - Cycle N+1: read_en=1, read_ptr=rd_cnt+1; rd_cnt increments at the end of N+1.
  - Outside a pending read, read_ptr=rd_cnt.
  - Cycle N+2: tx_data_valid or rx_data_valid pulses for one cycle, according to the latched source.
- Back-to-back gets are legal, giving one byte per cycle with a 2-cycle latency.
- buff_occ = wr_cnt - rd_cnt - pending. It is the registered count as of the cycle start.
  - full and empty are derived from buff_occ.
  - A get in the same cycle as a write to an empty buffer is rejected; underflow is set.
- Get while empty: no read is scheduled and underflow is set.
- Simultaneous accepted store and get: both proceed; occupancy is unchanged net.
- Non-circular buffer: when a read completes and leaves wr_cnt==rd_cnt, with no write in that cycle, both counters return to 0 at the next edge.
- clear or flush: highest priority; acts at the next edge.
  - Counters go to 0, any pending read is cancelled (no valid pulse) and all sticky flags are cleared.
  - write_en and read_en are forced to 0 in the cycle where clear or flush is asserted.
- Reset mid-read: the pending read is dropped immediately and the valid pulse is suppressed.
- Width: all pointer arithmetic is PTR_W bits; wr_cnt never exceeds DEPTH.

Test Plan:
- Reset release, then 3 stores, then 3 back-to-back get_tx_data:
  - write_ptr reads 1,2,3 with write_en on each store.
  - read_en follows each get by 1 cycle with read_ptr 1,2,3.
  - tx_data_valid pulses at +2 cycles.
  - After the last read, empty=1 and both pointers are 0.
- 64 stores, then a 65th store: full=1 after the 64th; the 65th gives write_en=0 and overflow=1; buff_occ=64.
- get_rx_data on an empty buffer: read_en never asserts, underflow=1, rx_data_valid stays 0.
- get_tx_data and get_rx_data together with 2 bytes stored: only tx is served; tx_data_valid pulses once; buff_occ decrements from 2 to 1.
- 5 stores, one get, then flush asserted in the read_en cycle:
  - No valid pulse follows.
  - Next cycle: buff_occ=0, pointers 0, flags cleared.
- store_tx_data and store_rx_data together with buffer at occupancy 10: buff_occ becomes 11 and store_collision=1; rst mid-stream returns all outputs to reset values asynchronously.
